// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_gen
// Description : Serial MSB-first pattern transmitter with repeat, inter-frame
//               gap and abort. Optional PRBS7 gap fill: SEQ_GEN_PRBS_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int W  = 8,
    parameter int CW = 4,
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [3:0]    len,
    input  logic [CW-1:0] reps,
    input  logic [GW-1:0] gap,
    input  logic          abort,
    output logic          x,
    output logic          x_valid,
    output logic          frame_start,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;
    localparam logic [3:0] c_W    = 4'(W);

    logic [1:0]    r_state,     w_state_n;
    logic [W-1:0]  r_pat,       w_pat_n;
    logic [3:0]    r_len,       w_len_n;
    logic [CW-1:0] r_reps,      w_reps_n;
    logic [GW-1:0] r_gap,       w_gap_n;
    logic [CW-1:0] r_frame_cnt, w_frame_cnt_n;
    logic [GW-1:0] r_gap_cnt,   w_gap_cnt_n;
    logic [3:0]    r_bit_idx,   w_bit_idx_n;
    logic          r_x,         w_x_n;
    logic          r_x_valid,   w_x_valid_n;
    logic          r_frame_start, w_frame_start_n;
    logic          r_busy,      w_busy_n;
    logic          r_done,      w_done_n;
    logic [3:0]    w_len_clamp;
    logic [CW-1:0] w_frame_inc;
    logic          w_fill;

    function automatic logic pick_bit(input logic [W-1:0] pat, input logic [3:0] sel);
        logic b;
        b = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (4'(k) == sel) b = pat[k];
        end
        return b;
    endfunction

    assign w_len_clamp = (len > c_W) ? c_W : len;
    assign w_frame_inc = r_frame_cnt + CW'(1);

    // Next-state values describe what the outputs show in the following cycle.
    always_comb begin
        w_state_n       = r_state;
        w_pat_n         = r_pat;
        w_len_n         = r_len;
        w_reps_n        = r_reps;
        w_gap_n         = r_gap;
        w_frame_cnt_n   = r_frame_cnt;
        w_gap_cnt_n     = r_gap_cnt;
        w_bit_idx_n     = r_bit_idx;
        w_x_n           = 1'b0;
        w_x_valid_n     = 1'b0;
        w_frame_start_n = 1'b0;
        w_busy_n        = 1'b0;
        w_done_n        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start && !abort && (len != 4'd0)) begin
                    w_pat_n         = pattern;
                    w_len_n         = w_len_clamp;
                    w_reps_n        = reps;
                    w_gap_n         = gap;
                    w_frame_cnt_n   = '0;
                    w_bit_idx_n     = 4'd0;
                    w_state_n       = c_SEND;
                    w_x_n           = pick_bit(pattern, w_len_clamp - 4'd1);
                    w_x_valid_n     = 1'b1;
                    w_frame_start_n = 1'b1;
                    w_busy_n        = 1'b1;
                end
            end
            c_SEND: begin
                if (abort) begin
                    w_state_n = c_IDLE;
                end else if (r_bit_idx == r_len - 4'd1) begin
                    w_frame_cnt_n = w_frame_inc;
                    if ((r_reps != '0) && (w_frame_inc == r_reps)) begin
                        w_state_n = c_IDLE;
                        w_done_n  = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_n   = c_GAP;
                        w_gap_cnt_n = '0;
                        w_x_n       = w_fill;
                        w_busy_n    = 1'b1;
                    end else begin
                        w_bit_idx_n     = 4'd0;
                        w_x_n           = pick_bit(r_pat, r_len - 4'd1);
                        w_x_valid_n     = 1'b1;
                        w_frame_start_n = 1'b1;
                        w_busy_n        = 1'b1;
                    end
                end else begin
                    w_bit_idx_n = r_bit_idx + 4'd1;
                    w_x_n       = pick_bit(r_pat, r_len - 4'd2 - r_bit_idx);
                    w_x_valid_n = 1'b1;
                    w_busy_n    = 1'b1;
                end
            end
            c_GAP: begin
                if (abort) begin
                    w_state_n = c_IDLE;
                end else if (r_gap_cnt == r_gap - GW'(1)) begin
                    w_state_n       = c_SEND;
                    w_bit_idx_n     = 4'd0;
                    w_x_n           = pick_bit(r_pat, r_len - 4'd1);
                    w_x_valid_n     = 1'b1;
                    w_frame_start_n = 1'b1;
                    w_busy_n        = 1'b1;
                end else begin
                    w_gap_cnt_n = r_gap_cnt + GW'(1);
                    w_x_n       = w_fill;
                    w_busy_n    = 1'b1;
                end
            end
            default: w_state_n = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_pat         <= '0;
            r_len         <= 4'd0;
            r_reps        <= '0;
            r_gap         <= '0;
            r_frame_cnt   <= '0;
            r_gap_cnt     <= '0;
            r_bit_idx     <= 4'd0;
            r_x           <= 1'b0;
            r_x_valid     <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_pat         <= w_pat_n;
            r_len         <= w_len_n;
            r_reps        <= w_reps_n;
            r_gap         <= w_gap_n;
            r_frame_cnt   <= w_frame_cnt_n;
            r_gap_cnt     <= w_gap_cnt_n;
            r_bit_idx     <= w_bit_idx_n;
            r_x           <= w_x_n;
            r_x_valid     <= w_x_valid_n;
            r_frame_start <= w_frame_start_n;
            r_busy        <= w_busy_n;
            r_done        <= w_done_n;
        end
    end

`ifdef SEQ_GEN_PRBS_FILL_EN
    // PRBS7 (x^7+x^6+1); steps once for every gap bit emitted.
    logic [6:0] r_lfsr;
    logic       w_fill_adv;
    assign w_fill     = r_lfsr[6] ^ r_lfsr[5];
    assign w_fill_adv = (w_state_n == c_GAP);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 7'h01;
        end else if (w_fill_adv) begin
            r_lfsr <= {r_lfsr[5:0], w_fill};
        end
    end
`else
    assign w_fill = 1'b0;
`endif

    assign x           = r_x;
    assign x_valid     = r_x_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_gen
// Description : Directed, table-driven self-checking bench for seq_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] pattern;
    logic [3:0] len, reps, gap;
    logic       x, x_valid, frame_start, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    seq_pattern_gen #(.W(8), .CW(4), .GW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .gap(gap), .abort(abort), .x(x), .x_valid(x_valid),
        .frame_start(frame_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One record: inputs for a cycle and the outputs expected after its edge.
    // exp = {x, x_valid, frame_start, busy, done}; gapc marks a gap-fill cycle.
    typedef struct {
        logic       rst, start, abort;
        logic [7:0] pat;
        logic [3:0] len, reps, gap;
        logic [4:0] exp;
        logic       gapc;
        string      name;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] c_pat;
    logic [3:0] c_len, c_reps, c_gap;
    string      c_name;
    logic [6:0] m_lfsr;

    task automatic cfg(input string nm, input logic [7:0] p, input logic [3:0] l,
                       input logic [3:0] r, input logic [3:0] g);
        c_name = nm; c_pat = p; c_len = l; c_reps = r; c_gap = g;
    endtask

    task automatic add(input logic r, input logic s, input logic a,
                       input logic [4:0] e, input logic gc);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.pat = c_pat; v.len = c_len;
        v.reps = c_reps; v.gap = c_gap; v.exp = e; v.gapc = gc; v.name = c_name;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] got, ex;
        logic       fb;
        @(negedge clk);
        rst = v.rst; start = v.start; abort = v.abort; pattern = v.pat;
        len = v.len; reps = v.reps; gap = v.gap;
        @(posedge clk);
        #1;
        ex = v.exp;
        if (v.rst) m_lfsr = 7'h01;
        if (v.gapc) begin
            fb = m_lfsr[6] ^ m_lfsr[5];
            m_lfsr = {m_lfsr[5:0], fb};
`ifdef SEQ_GEN_PRBS_FILL_EN
            ex[4] = fb;
`else
            ex[4] = 1'b0;
`endif
        end
        got = {x, x_valid, frame_start, busy, done};
        n_tests++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL %s: got {x,vld,fs,busy,done}=%b expected %b", v.name, got, ex);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; len = '0; reps = '0; gap = '0;
        m_lfsr = 7'h01;

        cfg("reset", 8'h00, 4'd0, 4'd0, 4'd0);
        add(1, 0, 0, 5'b00000, 0);
        add(1, 0, 0, 5'b00000, 0);

        cfg("single", 8'b0000_1001, 4'd4, 4'd1, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b01010, 0);
        add(0, 0, 0, 5'b11010, 0); add(0, 0, 0, 5'b00001, 0); add(0, 0, 0, 5'b00000, 0);

        cfg("repgap", 8'b0000_1001, 4'd4, 4'd3, 4'd2);
        add(0, 1, 0, 5'b11110, 0);
        for (int f = 0; f < 3; f++) begin
            if (f != 0) add(0, 0, 0, 5'b11110, 0);
            add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b11010, 0);
            if (f != 2) begin add(0, 0, 0, 5'b00010, 1); add(0, 0, 0, 5'b00010, 1); end
        end
        add(0, 0, 0, 5'b00001, 0); add(0, 0, 0, 5'b00000, 0);

        cfg("b2b_frames", 8'b0000_0010, 4'd2, 4'd2, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0);
        add(0, 0, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b00001, 0);

        cfg("abort", 8'b0000_1001, 4'd4, 4'd0, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b01010, 0);
        add(0, 0, 0, 5'b11010, 0); add(0, 0, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0);
        add(0, 0, 1, 5'b00000, 0); add(0, 0, 0, 5'b00000, 0); add(0, 0, 0, 5'b00000, 0);

        cfg("rst_mid", 8'b0000_1001, 4'd4, 4'd0, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b01010, 0);
        add(1, 0, 0, 5'b00000, 0); add(0, 0, 0, 5'b00000, 0);

        cfg("start_busy", 8'b0000_1001, 4'd4, 4'd1, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0);
        cfg("start_busy", 8'hFF, 4'd8, 4'd5, 4'd3);
        add(0, 1, 0, 5'b01010, 0); add(0, 0, 0, 5'b11010, 0);
        add(0, 0, 0, 5'b00001, 0); add(0, 0, 0, 5'b00000, 0);

        cfg("len_zero", 8'hFF, 4'd0, 4'd1, 4'd0);
        add(0, 1, 0, 5'b00000, 0); add(0, 0, 0, 5'b00000, 0);

        cfg("start_abort", 8'hFF, 4'd4, 4'd1, 4'd0);
        add(0, 1, 1, 5'b00000, 0); add(0, 0, 0, 5'b00000, 0);

        // Clamped 8-bit frame, then a new start issued in its done cycle.
        cfg("clamp", 8'b1011_0010, 4'd15, 4'd1, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b11010, 0);
        add(0, 0, 0, 5'b11010, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b01010, 0);
        add(0, 0, 0, 5'b11010, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b00001, 0);
        cfg("done_restart", 8'b0000_1001, 4'd4, 4'd1, 4'd0);
        add(0, 1, 0, 5'b11110, 0); add(0, 0, 0, 5'b01010, 0); add(0, 0, 0, 5'b01010, 0);
        add(0, 0, 0, 5'b11010, 0); add(0, 0, 0, 5'b00001, 0); add(0, 0, 0, 5'b00000, 0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Gap fill sequence: one-bit frames around a 7-cycle gap, from a fresh reset.
        tbl.delete();
        cfg("prbs_gap", 8'b0000_0001, 4'd1, 4'd2, 4'd7);
        add(1, 0, 0, 5'b00000, 0);
        add(0, 1, 0, 5'b11110, 0);
        for (int g = 0; g < 7; g++) add(0, 0, 0, 5'b00010, 1);
        add(0, 0, 0, 5'b11110, 0);
        add(0, 0, 0, 5'b00001, 0);
        add(0, 0, 0, 5'b00000, 0);
        foreach (tbl[i]) run_vec(tbl[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
